// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the EX-stage branch resolver and its BHT.
package branch_resolver_pkg;

  // Control-flow type carried down the pipe with each instruction
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_JAL  = 2'b10,
    BR_JALR = 2'b11
  } br_type_e;

  typedef logic [1:0] bht_cnt_t;

  // Weakly not-taken: agrees with the static not-taken policy for B-type
  localparam bht_cnt_t BHT_INIT = 2'b01;

  // Two-bit saturating counter step
  function automatic bht_cnt_t bht_sat_update(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Pipeline-facing bundle of the branch resolver: IF/ID lookup, EX resolve,
// redirect and statistics. The pipeline side is master, the resolver is slave.
interface branch_resolver_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);

  logic [XLEN-1:0]  lookup_pc;
  logic             lookup_taken;

  logic             ex_valid;
  logic             ex_stall;
  logic [1:0]       ex_br_type;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             ex_act_taken;
  logic [XLEN-1:0]  ex_act_target;

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output lookup_pc,
    input  lookup_taken,
    output ex_valid, ex_stall, ex_br_type, ex_pc,
    output ex_pred_taken, ex_pred_target, ex_act_taken, ex_act_target,
    input  redirect_valid, redirect_pc,
    input  branch_cnt, mispred_cnt
  );

  modport slave (
    input  lookup_pc,
    output lookup_taken,
    input  ex_valid, ex_stall, ex_br_type, ex_pc,
    input  ex_pred_taken, ex_pred_target, ex_act_taken, ex_act_target,
    output redirect_valid, redirect_pc,
    output branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/branch_resolver_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read
// port returning the prediction bit and one clocked saturating-update port.
module bht_table
  import branch_resolver_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  bht_cnt_t bht_q [DEPTH];
  bht_cnt_t bht_d [DEPTH];

  // Next table contents: only the trained entry moves
  always_comb begin
    bht_d = bht_q;
    if (wr_en) begin
      bht_d[wr_idx] = bht_sat_update(bht_q[wr_idx], wr_taken);
    end
  end

  // Counter array; asynchronous reset to weakly not-taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bht_q <= '{default: BHT_INIT};
    end else begin
      bht_q <= bht_d;
    end
  end

  // Read sees registered state only, so a same-cycle update is not bypassed
  assign rd_taken = bht_q[rd_idx][1];

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: compares the carried prediction with the actual
// outcome, drives a zero-latency redirect, trains the BHT on B-type resolves
// and keeps resolve/mispredict statistics.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned CNT_W     = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  branch_resolver_if.slave br
);

  br_type_e             ex_type;
  logic                 res;
  logic                 act_t;
  logic                 mis;
  logic                 train;
  logic [XLEN-1:0]      seq_pc;
  logic [BHT_IDX_W-1:0] lookup_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 unused_lookup_bits;

  logic [CNT_W-1:0]     branch_cnt_q;
  logic [CNT_W-1:0]     branch_cnt_d;
  logic [CNT_W-1:0]     mispred_cnt_q;
  logic [CNT_W-1:0]     mispred_cnt_d;

  assign ex_type    = br_type_e'(br.ex_br_type);
  assign lookup_idx = br.lookup_pc[BHT_IDX_W+1:2];
  assign ex_idx     = br.ex_pc[BHT_IDX_W+1:2];

  // PC bits outside the index field do not take part in the lookup
  assign unused_lookup_bits = ^{br.lookup_pc[XLEN-1:BHT_IDX_W+2], br.lookup_pc[1:0]};

  // Resolve qualification, actual outcome and mispredict detection
  always_comb begin
    res    = br.ex_valid & ~br.ex_stall & (ex_type != BR_NONE);
    act_t  = (ex_type == BR_B) ? br.ex_act_taken : 1'b1;
    mis    = res & ((br.ex_pred_taken != act_t) |
                    (act_t & br.ex_pred_taken & (br.ex_pred_target != br.ex_act_target)));
    train  = res & (ex_type == BR_B);
    seq_pc = br.ex_pc + XLEN'(4);
  end

  // Redirect to the pipeline; forced quiet while reset is asserted
  always_comb begin
    br.redirect_valid = 1'b0;
    br.redirect_pc    = '0;
    if (!cpu_rst) begin
      br.redirect_valid = mis;
      br.redirect_pc    = (mis & act_t) ? br.ex_act_target : seq_pc;
    end
  end

  // Statistics next-state: wrap naturally at 2**CNT_W
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res) branch_cnt_d  = branch_cnt_q + CNT_W'(1);
    if (mis) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  // Statistics registers
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br.branch_cnt  = branch_cnt_q;
  assign br.mispred_cnt = mispred_cnt_q;

  bht_table #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .rd_idx   (lookup_idx),
    .rd_taken (br.lookup_taken),
    .wr_en    (train),
    .wr_idx   (ex_idx),
    .wr_taken (br.ex_act_taken)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: inputs change on the falling edge,
// outputs are checked a few ns later, well clear of the rising edge.
module tb_branch_resolver;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  int unsigned errors  = 0;
  int unsigned checks  = 0;

  branch_resolver_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_resolver #(
    .XLEN      (32),
    .BHT_IDX_W (6),
    .CNT_W     (32)
  ) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .br      (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic [1:0] t,
                       input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic at, input logic [31:0] atg);
    bus.ex_valid       = v;
    bus.ex_stall       = s;
    bus.ex_br_type     = t;
    bus.ex_pc          = pc;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptg;
    bus.ex_act_taken   = at;
    bus.ex_act_target  = atg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    bus.lookup_pc = pc;
    #1;
    chk1(tag, bus.lookup_taken, exp);
  endtask

  task automatic counts(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk32({tag, "_branch_cnt"}, bus.branch_cnt, b);
    chk32({tag, "_mispred_cnt"}, bus.mispred_cnt, m);
  endtask

  initial begin
    bus.lookup_pc = 32'h0;
    idle();

    // Reset masks a would-be mispredict on the redirect outputs
    drive(1'b1, 1'b0, 2'b01, 32'h80, 1'b0, 32'h0, 1'b1, 32'hC0);
    #1;
    chk1("rst_redirect_valid", bus.redirect_valid, 1'b0);
    chk32("rst_redirect_pc", bus.redirect_pc, 32'h0);
    cycle();
    #1;
    counts("rst", 32'd0, 32'd0);

    // Release reset, idle for 10 cycles
    idle();
    cpu_rst = 1'b0;
    lookup("idle_lookup_100", 32'h100, 1'b0);
    repeat (10) begin
      cycle();
      #1;
      chk1("idle_redirect_valid", bus.redirect_valid, 1'b0);
    end
    counts("idle", 32'd0, 32'd0);

    // B not-taken, predicted not-taken at 0x40 (idx 0x10: 01 -> 00)
    drive(1'b1, 1'b0, 2'b01, 32'h40, 1'b0, 32'h0, 1'b0, 32'h60);
    #1;
    chk1("b_nn_redirect_valid", bus.redirect_valid, 1'b0);
    cycle();
    idle();
    #1;
    counts("b_nn", 32'd1, 32'd0);
    lookup("b_nn_lookup_40", 32'h40, 1'b0);

    // B taken, predicted not-taken at 0x80 (idx 0x20: 01 -> 10)
    drive(1'b1, 1'b0, 2'b01, 32'h80, 1'b0, 32'h0, 1'b1, 32'hC0);
    #1;
    chk1("b_tn_redirect_valid", bus.redirect_valid, 1'b1);
    chk32("b_tn_redirect_pc", bus.redirect_pc, 32'hC0);
    cycle();
    idle();
    #1;
    counts("b_tn", 32'd2, 32'd1);
    lookup("b_tn_lookup_80", 32'h80, 1'b1);

    // Three more taken resolves: 10 -> 11 -> 11 -> 11
    drive(1'b1, 1'b0, 2'b01, 32'h80, 1'b0, 32'h0, 1'b1, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("b_rep_redirect_valid", bus.redirect_valid, 1'b1);
      cycle();
    end
    idle();
    #1;
    counts("b_rep", 32'd5, 32'd4);
    lookup("b_rep_lookup_80", 32'h80, 1'b1);

    // Not-taken, predicted taken: 11 -> 10, redirect to fall-through
    drive(1'b1, 1'b0, 2'b01, 32'h80, 1'b1, 32'hC0, 1'b0, 32'hC0);
    #1;
    chk1("sat_dec1_redirect_valid", bus.redirect_valid, 1'b1);
    chk32("sat_dec1_redirect_pc", bus.redirect_pc, 32'h84);
    cycle();
    idle();
    #1;
    counts("sat_dec1", 32'd6, 32'd5);
    lookup("sat_dec1_lookup_80", 32'h80, 1'b1);

    // Not-taken, predicted not-taken: 10 -> 01
    drive(1'b1, 1'b0, 2'b01, 32'h80, 1'b0, 32'h0, 1'b0, 32'hC0);
    #1;
    chk1("sat_dec2_redirect_valid", bus.redirect_valid, 1'b0);
    cycle();
    idle();
    #1;
    counts("sat_dec2", 32'd7, 32'd5);
    lookup("sat_dec2_lookup_80", 32'h80, 1'b0);

    // JALR target mismatch at 0x300 (idx 0); ex_act_taken=1 must not train
    drive(1'b1, 1'b0, 2'b11, 32'h300, 1'b1, 32'h200, 1'b1, 32'h204);
    #1;
    chk1("jalr_redirect_valid", bus.redirect_valid, 1'b1);
    chk32("jalr_redirect_pc", bus.redirect_pc, 32'h204);
    cycle();
    idle();
    #1;
    counts("jalr", 32'd8, 32'd6);
    lookup("jalr_no_train_lookup_300", 32'h300, 1'b0);

    // JAL correctly predicted; ex_act_taken=0 must be ignored
    drive(1'b1, 1'b0, 2'b10, 32'h400, 1'b1, 32'h500, 1'b0, 32'h500);
    #1;
    chk1("jal_redirect_valid", bus.redirect_valid, 1'b0);
    cycle();
    idle();
    #1;
    counts("jal", 32'd9, 32'd6);

    // Valid instruction with type none: no effect
    drive(1'b1, 1'b0, 2'b00, 32'h500, 1'b1, 32'h10, 1'b0, 32'h20);
    #1;
    chk1("none_redirect_valid", bus.redirect_valid, 1'b0);
    cycle();
    idle();
    #1;
    counts("none", 32'd9, 32'd6);

    // Mispredicting B at 0x10 (idx 4) held for 3 stalled edges
    drive(1'b1, 1'b1, 2'b01, 32'h10, 1'b0, 32'h0, 1'b1, 32'h1000);
    repeat (3) begin
      #1;
      chk1("stall_redirect_valid", bus.redirect_valid, 1'b0);
      cycle();
    end
    counts("stall", 32'd9, 32'd6);
    lookup("stall_lookup_10", 32'h10, 1'b0);
    bus.ex_stall = 1'b0;
    #1;
    chk1("unstall_redirect_valid", bus.redirect_valid, 1'b1);
    chk32("unstall_redirect_pc", bus.redirect_pc, 32'h1000);
    cycle();
    idle();
    #1;
    chk1("unstall_after_redirect_valid", bus.redirect_valid, 1'b0);
    counts("unstall", 32'd10, 32'd7);
    lookup("unstall_lookup_10", 32'h10, 1'b1);

    // Collision: train idx 5 taken while looking it up
    bus.lookup_pc = 32'h14;
    drive(1'b1, 1'b0, 2'b01, 32'h14, 1'b1, 32'h2000, 1'b1, 32'h2000);
    #1;
    chk1("coll_old_lookup", bus.lookup_taken, 1'b0);
    chk1("coll_redirect_valid", bus.redirect_valid, 1'b0);
    cycle();
    idle();
    #1;
    chk1("coll_new_lookup", bus.lookup_taken, 1'b1);
    counts("coll", 32'd11, 32'd7);

    // Fall-through wraps modulo 2**32
    drive(1'b1, 1'b0, 2'b01, 32'hFFFF_FFFC, 1'b1, 32'h8, 1'b0, 32'h8);
    #1;
    chk1("wrap_redirect_valid", bus.redirect_valid, 1'b1);
    chk32("wrap_redirect_pc", bus.redirect_pc, 32'h0);
    cycle();
    idle();
    #1;
    counts("wrap", 32'd12, 32'd8);

    // Asynchronous reset mid-cycle with a mispredict in flight
    drive(1'b1, 1'b0, 2'b01, 32'h14, 1'b0, 32'h0, 1'b1, 32'h3000);
    #1;
    chk1("pre_ar_redirect_valid", bus.redirect_valid, 1'b1);
    #1;
    cpu_rst = 1'b1;
    #1;
    counts("ar", 32'd0, 32'd0);
    chk1("ar_redirect_valid", bus.redirect_valid, 1'b0);
    chk32("ar_redirect_pc", bus.redirect_pc, 32'h0);
    lookup("ar_lookup_14", 32'h14, 1'b0);
    cycle();
    lookup("ar_lookup_10", 32'h10, 1'b0);
    counts("ar_hold", 32'd0, 32'd0);
    idle();
    cpu_rst = 1'b0;

    // First resolve after reset
    drive(1'b1, 1'b0, 2'b01, 32'h10, 1'b0, 32'h0, 1'b1, 32'h44);
    #1;
    chk1("post_ar_redirect_valid", bus.redirect_valid, 1'b1);
    chk32("post_ar_redirect_pc", bus.redirect_pc, 32'h44);
    cycle();
    idle();
    #1;
    counts("post_ar", 32'd1, 32'd1);
    lookup("post_ar_lookup_10", 32'h10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
Resolves control-flow predictions in the EX stage and trains the dynamic predictor table. IF/ID lookups read the table; this block compares each EX-stage prediction with the actual outcome. On a mismatch it drives the flush/redirect, then updates a 2-bit saturating branch history table (BHT). It sits beside the EX stage and drives the pipeline flush and the IF next-PC mux.

Parameters:
XLEN, 32, datapath/PC width
BHT_IDX_W, 6, BHT index width; table depth = 2**BHT_IDX_W
CNT_W, 32, width of the statistics counters

Ports:
cpu_clk  input  1  core clock, all state updates on rising edge
cpu_rst  input  1  reset, asynchronous, active-high
lookup_pc  input  XLEN  PC of the instruction being predicted in IF/ID
lookup_taken  output  1  BHT prediction for lookup_pc (counter MSB)
ex_valid  input  1  EX holds a real instruction
ex_stall  input  1  EX is held this cycle
ex_br_type  input  2  00 none, 01 B-type, 10 JAL, 11 JALR
ex_pc  input  XLEN  PC of the EX instruction
ex_pred_taken  input  1  prediction carried down the pipe
ex_pred_target  input  XLEN  predicted target carried down the pipe
ex_act_taken  input  1  ALU branch-condition result (JAL/JALR: ignored, treated as 1)
ex_act_target  input  XLEN  computed target (pc+imm, or (rs1+imm)&~1)
redirect_valid  output  1  mispredict: flush IF/ID and ID/EX, load redirect_pc
redirect_pc  output  XLEN  correct next PC
branch_cnt  output  CNT_W  resolved control-flow instructions
mispred_cnt  output  CNT_W  mispredictions

Behaviour:
- Clock and reset: one clock, cpu_clk. cpu_rst is asynchronous and active-high.
- Reset values: all BHT entries = 2'b01 (weakly not-taken, matching the static not-taken policy for B); branch_cnt = 0; mispred_cnt = 0.
- Outputs during reset: redirect_valid = 0 and redirect_pc = 0 while cpu_rst is high, regardless of inputs.
- Resolve qualifier: res = ex_valid & ~ex_stall & (ex_br_type != 00).
- Actual outcome: act_t = ex_act_taken for B-type; act_t = 1 for JAL and JALR.
- Mispredict condition: mis = res & ((ex_pred_taken != act_t) | (act_t & ex_pred_taken & (ex_pred_target != ex_act_target))).
- Redirect timing: redirect_valid = mis, combinational, in the same cycle as the resolve. Zero latency, so the pipeline flush lands on the same edge.
- Redirect target: redirect_pc = act_t ? ex_act_target : ex_pc + 4, modulo 2**XLEN. When redirect_valid = 0, redirect_pc = ex_pc + 4 and is don't-care to consumers.
- Stall: while ex_stall = 1 there is no redirect, no training and no count. The instruction resolves in the first non-stalled cycle, exactly once.
- Table index: idx = pc[BHT_IDX_W+1:2]. PC bits [1:0] are ignored.
- Lookup: lookup_taken = bht[idx(lookup_pc)][1]. The read is combinational.
- Training, at the clock edge when res & (ex_br_type == 01):
  - if ex_act_taken: counter increments, saturating at 11.
  - otherwise: counter decrements, saturating at 00.
  - JAL and JALR never train the table.
- Write/read collision: a lookup to the index being trained in the same cycle returns the pre-update value. There is no bypass.
- Statistics:
  - branch_cnt increments by 1 at each edge where res = 1.
  - mispred_cnt increments by 1 at each edge where mis = 1.
  - Both wrap modulo 2**CNT_W.
- Asynchronous reset mid-operation: all state returns to reset values immediately. An in-flight resolve in that cycle is dropped, with no training and no count.
- Invalid type: ex_br_type = 00 with ex_valid = 1 has no effect on any output or state.

Decomposition:
- Shared constants go in define.v:
  - branch type codes: `BR_NONE 2'b00`, `BR_B 2'b01`, `BR_JAL 2'b10`, `BR_JALR 2'b11`.
  - BHT reset value: `BHT_INIT 2'b01`.
- Sub-module bht_table holds the counter array. It has one asynchronous read port, one synchronous saturating-update port, and handles the asynchronous reset to BHT_INIT.
- branch_resolver keeps the compare, redirect and statistics logic.

Test Plan:
- Reset then idle: after reset, lookup_pc=0x100 -> lookup_taken=0. Hold ex_valid=0 for 10 cycles -> redirect_valid=0, branch_cnt=0, mispred_cnt=0.
- B not-taken, predicted not-taken: ex_pc=0x40, type=01, pred=0, act=0 -> redirect_valid=0, branch_cnt=1. The counter at idx 0x10 goes 01->00; lookup 0x40 then returns 0.
- B taken, predicted not-taken: ex_pc=0x80, target=0xC0, act=1 -> redirect_valid=1 with redirect_pc=0xC0, mispred_cnt=1. Counter 01->10, so next lookup of 0x80 returns 1. Repeat 3 times -> counter saturates at 11.
- JALR target mismatch: type=11, pred_taken=1, pred_target=0x200, act_target=0x204 -> redirect_valid=1, redirect_pc=0x204. The BHT is unchanged.
- Stall then resolve: a mispredicting B is held with ex_stall=1 for 3 cycles -> redirect_valid=0 throughout. When stall drops, redirect_valid=1 for exactly 1 cycle and mispred_cnt increments by exactly 1.
- Collision and async reset:
  - train idx 5 taken while lookup_pc maps to idx 5 -> lookup returns the old MSB in that cycle and the new MSB in the next cycle.
  - assert cpu_rst mid-cycle -> counters and table return to reset values immediately.
